sum_frame_feeder: RTL and testbench

Front-end sequencer for the parallel N-integer summer. It accepts operands one per beat on a valid/ready stream and assembles a frame of N values. It presents the frame as a stable parallel bus, pulses `sum_start`, and waits for the summer's `sum_done`. It then returns the captured sum, or a timeout error, on a valid/ready result port.

---
 rtl/sum_pkg.sv | 18 +
 rtl/sum_frame_feeder_if.sv | 33 +++
 rtl/sum_operand_buf.sv | 27 ++
 rtl/sum_frame_feeder.sv | 100 ++++++++++
 tb/tb_sum_frame_feeder.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/sum_pkg.sv
// Shared types and defaults for the N-operand summer front end.
package sum_pkg;

  typedef enum logic [1:0] {
    FILL   = 2'd0,
    START  = 2'd1,
    WAIT   = 2'd2,
    RESULT = 2'd3
  } state_t;

  localparam int SUM_N    = 30;
  localparam int SUM_W_IN = 5;

  function automatic int sum_width(input int n, input int w);
    return w + $clog2(n);
  endfunction

endpackage

// File: rtl/sum_frame_feeder_if.sv
// Operand stream, summer handshake and result stream of the frame feeder.
interface sum_frame_feeder_if
  import sum_pkg::*;
#(
  parameter int N     = SUM_N,
  parameter int W     = SUM_W_IN,
  parameter int SUM_W = sum_width(SUM_N, SUM_W_IN)
) ();

  logic             in_valid;
  logic             in_ready;
  logic [W-1:0]     in_data;
  logic [N*W-1:0]   nums;
  logic             sum_start;
  logic             sum_done;
  logic [SUM_W-1:0] sum_result;
  logic             res_valid;
  logic             res_ready;
  logic [SUM_W-1:0] res_data;
  logic             res_err;

  // master drives operands and consumes results; slave is the feeder
  modport master (
    output in_valid, in_data, sum_done, sum_result, res_ready,
    input  in_ready, nums, sum_start, res_valid, res_data, res_err
  );

  modport slave (
    input  in_valid, in_data, sum_done, sum_result, res_ready,
    output in_ready, nums, sum_start, res_valid, res_data, res_err
  );

endinterface

// File: rtl/sum_operand_buf.sv
// N x W operand register file: one indexed write port, flattened parallel read.
module sum_operand_buf #(
  parameter int N     = 30,
  parameter int W     = 5,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [W-1:0]     wr_data,
  output logic [N*W-1:0]   rd_data
);

  logic [N*W-1:0] mem;

  always_ff @(posedge clk) begin
    if (rst) begin
      mem <= '0;
    end else if (wr_en) begin
      mem[int'(wr_idx)*W +: W] <= wr_data;
    end
  end

  assign rd_data = mem;

endmodule

// File: rtl/sum_frame_feeder.sv
// Collects N operand beats, kicks the summer, and returns its sum (or a timeout error).
module sum_frame_feeder
  import sum_pkg::*;
#(
  parameter int N       = SUM_N,
  parameter int W       = SUM_W_IN,
  parameter int SUM_W   = sum_width(N, W),
  parameter int TIMEOUT = 16
) (
  input logic              clk,
  input logic              rst,
  sum_frame_feeder_if.slave bus
);

  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam int TMR_W = $clog2(TIMEOUT + 1);

  localparam logic [1:0] S_FILL   = FILL;
  localparam logic [1:0] S_START  = START;
  localparam logic [1:0] S_WAIT   = WAIT;
  localparam logic [1:0] S_RESULT = RESULT;

  logic [1:0]       state;
  logic [IDX_W-1:0] idx;
  logic [TMR_W-1:0] timer;
  logic [SUM_W-1:0] res_data_q;
  logic             res_err_q;
  logic             wr_en;
  logic [N*W-1:0]   nums_w;

  assign wr_en = (state == S_FILL) && bus.in_valid;

  sum_operand_buf #(
    .N     (N),
    .W     (W),
    .IDX_W (IDX_W)
  ) u_operand_buf (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_idx  (idx),
    .wr_data (bus.in_data),
    .rd_data (nums_w)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_FILL;
      idx        <= '0;
      timer      <= '0;
      res_data_q <= '0;
      res_err_q  <= 1'b0;
    end else begin
      case (state)
        S_FILL: begin
          if (bus.in_valid) begin
            if (idx == IDX_W'(N - 1)) begin
              idx   <= '0;
              state <= S_START;
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end
        S_START: begin
          timer <= '0;
          state <= S_WAIT;
        end
        S_WAIT: begin
          timer <= timer + 1'b1;
          // a done landing on the last allowed cycle still counts as success
          if (bus.sum_done) begin
            res_data_q <= bus.sum_result;
            res_err_q  <= 1'b0;
            state      <= S_RESULT;
          end else if (timer == TMR_W'(TIMEOUT - 1)) begin
            res_data_q <= '0;
            res_err_q  <= 1'b1;
            state      <= S_RESULT;
          end
        end
        S_RESULT: begin
          if (bus.res_ready) begin
            state <= S_FILL;
          end
        end
        default: state <= S_FILL;
      endcase
    end
  end

  // handshake outputs come straight from the state register
  assign bus.in_ready  = (state == S_FILL);
  assign bus.sum_start = (state == S_START);
  assign bus.res_valid = (state == S_RESULT);
  assign bus.res_data  = res_data_q;
  assign bus.res_err   = res_err_q;
  assign bus.nums      = nums_w;

endmodule

// File: tb/tb_sum_frame_feeder.sv
// Bench for sum_frame_feeder: table vectors, random frames vs. a frame-level model, reset corners.
module tb_sum_frame_feeder;

  localparam int N       = 30;
  localparam int W       = 5;
  localparam int SUM_W   = 10;
  localparam int TIMEOUT = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sum_frame_feeder_if #(.N(N), .W(W), .SUM_W(SUM_W)) bus ();

  sum_frame_feeder #(.N(N), .W(W), .SUM_W(SUM_W), .TIMEOUT(TIMEOUT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int vectors     = 0;
  int miscompares = 0;
  int ops[N];

  typedef struct {
    int pattern;     // 0 ramp 1..N, 1 all 31, 2 all 2, 3 all 1
    int done_delay;  // cycles after sum_start; -1 = never
    int hold;        // cycles res_ready stays low in RESULT
    bit gaps;
    bit noise;       // stray sum_done in FILL, stray in_valid in WAIT/RESULT
    int exp_data;
    bit exp_err;
  } vec_t;

  vec_t tbl[7];

  task automatic check(input string name, input logic [N*W-1:0] act, input logic [N*W-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic make_ops(input int pattern);
    for (int k = 0; k < N; k++) begin
      case (pattern)
        0: ops[k] = k + 1;
        1: ops[k] = 31;
        2: ops[k] = 2;
        default: ops[k] = 1;
      endcase
    end
  endtask

  function automatic logic [N*W-1:0] pack_ops();
    logic [N*W-1:0] p;
    p = '0;
    for (int k = 0; k < N; k++) p[k*W +: W] = W'(ops[k]);
    return p;
  endfunction

  function automatic int ops_sum();
    int s;
    s = 0;
    for (int k = 0; k < N; k++) s += ops[k];
    return s;
  endfunction

  task automatic feed(input bit gaps, input bit noise);
    for (int k = 0; k < N; k++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          bus.in_valid   = 1'b0;
          bus.sum_done   = noise;
          bus.sum_result = '1;
          step();
        end
      end
      bus.in_valid   = 1'b1;
      bus.in_data    = W'(ops[k]);
      bus.sum_done   = noise;
      bus.sum_result = '1;
      step();
    end
    bus.in_valid   = noise;
    bus.in_data    = '1;
    bus.sum_done   = 1'b0;
    bus.sum_result = '0;
  endtask

  task automatic run_frame(input int d, input int hold, input bit gaps, input bit noise,
                           input int exp_data, input bit exp_err);
    logic [N*W-1:0] exp_nums;
    int rise;
    exp_nums = pack_ops();
    rise = (d >= 1 && d <= TIMEOUT) ? d + 1 : TIMEOUT + 1;
    check("in_ready_fill", bus.in_ready, 1);
    feed(gaps, noise);
    check("sum_start_pulse", bus.sum_start, 1);
    check("in_ready_start", bus.in_ready, 0);
    for (int c = 0; c < rise; c++) begin
      bus.sum_done   = (c == d);
      bus.sum_result = (c == d) ? SUM_W'(ops_sum()) : (noise ? '1 : '0);
      if (c == 1) begin
        check("nums_wait", bus.nums, exp_nums);
        check("sum_start_once", bus.sum_start, 0);
      end
      if (c == rise - 1) check("res_valid_early", bus.res_valid, 0);
      step();
    end
    bus.sum_done   = 1'b0;
    bus.sum_result = '0;
    check("res_valid_rise", bus.res_valid, 1);
    check("res_data", bus.res_data, exp_data);
    check("res_err", bus.res_err, exp_err);
    check("nums_result", bus.nums, exp_nums);
    bus.res_ready = 1'b0;
    for (int h = 0; h < hold; h++) step();
    if (hold > 0) begin
      check("res_data_held", bus.res_data, exp_data);
      check("res_valid_held", bus.res_valid, 1);
      check("in_ready_held", bus.in_ready, 0);
    end
    bus.res_ready = 1'b1;
    step();
    bus.res_ready = 1'b0;
    bus.in_valid  = 1'b0;
    check("in_ready_after", bus.in_ready, 1);
    check("res_valid_after", bus.res_valid, 0);
    check("res_err_kept", bus.res_err, exp_err);
    check("nums_unconsumed", bus.nums, exp_nums);
  endtask

  initial begin
    int d, s;
    bit e;

    tbl[0] = '{0,  8, 0, 1'b0, 1'b0, 465, 1'b0};
    tbl[1] = '{1,  6, 1, 1'b1, 1'b0, 930, 1'b0};
    tbl[2] = '{0, -1, 0, 1'b0, 1'b0,   0, 1'b1};
    tbl[3] = '{0,  8, 5, 1'b0, 1'b1, 465, 1'b0};
    tbl[4] = '{0, 16, 0, 1'b0, 1'b1, 465, 1'b0};
    tbl[5] = '{3, 17, 2, 1'b1, 1'b0,   0, 1'b1};
    tbl[6] = '{3,  1, 0, 1'b0, 1'b0,  30, 1'b0};

    bus.in_valid   = 1'b0;
    bus.in_data    = '0;
    bus.sum_done   = 1'b0;
    bus.sum_result = '0;
    bus.res_ready  = 1'b0;

    rst = 1'b1;
    repeat (3) step();
    check("rst_in_ready", bus.in_ready, 1);
    check("rst_sum_start", bus.sum_start, 0);
    check("rst_res_valid", bus.res_valid, 0);
    check("rst_res_data", bus.res_data, 0);
    check("rst_res_err", bus.res_err, 0);
    check("rst_nums", bus.nums, 0);
    rst = 1'b0;
    step();

    for (int i = 0; i < 7; i++) begin
      make_ops(tbl[i].pattern);
      run_frame(tbl[i].done_delay, tbl[i].hold, tbl[i].gaps, tbl[i].noise,
                tbl[i].exp_data, tbl[i].exp_err);
    end

    // random frames: summer answers after a random delay, possibly too late
    for (int r = 0; r < 15; r++) begin
      for (int k = 0; k < N; k++) ops[k] = $urandom_range(0, 31);
      d = $urandom_range(1, TIMEOUT + 3);
      s = ops_sum();
      e = (d > TIMEOUT);
      run_frame(d, $urandom_range(0, 3), $urandom_range(0, 1), $urandom_range(0, 1),
                e ? 0 : s, e);
    end

    // reset after 12 operands discards the partial frame
    for (int k = 0; k < 12; k++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 5'd7;
      step();
    end
    bus.in_valid = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("midrst_nums", bus.nums, 0);
    check("midrst_in_ready", bus.in_ready, 1);
    make_ops(2);
    run_frame(5, 0, 1'b0, 1'b0, 60, 1'b0);

    // reset while waiting; a late sum_done must not produce a result
    make_ops(0);
    feed(1'b0, 1'b0);
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    bus.sum_done   = 1'b1;
    bus.sum_result = 10'd465;
    step();
    bus.sum_done   = 1'b0;
    bus.sum_result = '0;
    for (int k = 0; k < 3; k++) begin
      check("waitrst_res_valid", bus.res_valid, 0);
      step();
    end
    check("waitrst_in_ready", bus.in_ready, 1);
    check("waitrst_res_data", bus.res_data, 0);
    check("waitrst_nums", bus.nums, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
